// File: rtl/muldiv_if.sv
// Handshake bundle between the execute stage and the multiply/divide unit.
// Carries the operation request, the HI/LO moves and the HI/LO/status results.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] rs_i;
  logic [WIDTH-1:0] rt_i;
  logic             mthi_i;
  logic             mtlo_i;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output start_i, op_i, rs_i, rt_i, mthi_i, mtlo_i,
    input  hi_o, lo_o, busy_o, done_o
  );

  modport slave (
    input  start_i, op_i, rs_i, rt_i, mthi_i, mtlo_i,
    output hi_o, lo_o, busy_o, done_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               divzero;
  logic [WIDTH-1:0]   mag;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic               busy;
  logic               done;

  logic               sgn_op;
  logic               rs_neg;
  logic               rt_neg;
  logic [WIDTH-1:0]   rs_abs;
  logic [WIDTH-1:0]   rt_abs;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     trial;
  logic [WIDTH+1:0]   diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rmd;

  always_comb begin
    sgn_op  = ~bus.op_i[0];
    rs_neg  = sgn_op & bus.rs_i[WIDTH-1];
    rt_neg  = sgn_op & bus.rt_i[WIDTH-1];
    rs_abs  = rs_neg ? -bus.rs_i : bus.rs_i;
    rt_abs  = rt_neg ? -bus.rt_i : bus.rt_i;
    add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
            + (acc[0] ? {1'b0, mag} : '0);
    trial   = {rem, acc[WIDTH-1]};
    diff    = {1'b0, trial} - {2'b00, mag};
    prod    = neg_q ? -acc : acc;
    quo     = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rmd     = neg_r ? -rem : rem;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      divzero <= 1'b0;
      mag     <= '0;
      acc     <= '0;
      rem     <= '0;
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start_i) begin
            is_div  <= bus.op_i[1];
            neg_q   <= rs_neg ^ rt_neg;
            neg_r   <= rs_neg;
            divzero <= bus.op_i[1] & (bus.rt_i == '0);
            rem     <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= CALC;
            if (bus.op_i[1]) begin
              mag <= rt_abs;
              // divide-by-zero keeps the raw dividend for HI
              acc <= {{WIDTH{1'b0}},
                      (bus.rt_i == '0) ? bus.rs_i : rs_abs};
            end else begin
              mag <= rs_abs;
              acc <= {{WIDTH{1'b0}}, rt_abs};
            end
          end else begin
            if (bus.mthi_i) hi <= bus.rs_i;
            if (bus.mtlo_i) lo <= bus.rs_i;
          end
        end
        CALC: begin
          if (!divzero) begin
            if (is_div) begin
              if (!diff[WIDTH+1]) begin
                rem            <= diff[WIDTH-1:0];
                acc[WIDTH-1:0] <= {acc[WIDTH-2:0], 1'b1};
              end else begin
                rem            <= trial[WIDTH-1:0];
                acc[WIDTH-1:0] <= {acc[WIDTH-2:0], 1'b0};
              end
            end else begin
              acc <= {add_sum, acc[WIDTH-1:1]};
            end
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          if (divzero) begin
            hi <= acc[WIDTH-1:0];
            lo <= '1;
          end else if (is_div) begin
            hi <= rmd;
            lo <= quo;
          end else begin
            hi <= prod[2*WIDTH-1:WIDTH];
            lo <= prod[WIDTH-1:0];
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.hi_o   = hi;
  assign bus.lo_o   = lo;
  assign bus.busy_o = busy;
  assign bus.done_o = done;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit: multiply, divide, moves,
// ignored inputs while busy and mid-operation reset.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  muldiv_if #(.WIDTH(32)) mif ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mif)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    mif.start_i = 1'b0;
    mif.op_i    = 2'b00;
    mif.rs_i    = '0;
    mif.rt_i    = '0;
    mif.mthi_i  = 1'b0;
    mif.mtlo_i  = 1'b0;
  endtask

  // Runs one op; sample i is taken after edge E(i), E0 samples start.
  task automatic do_op(
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mv,
    input  int          inj,
    input  logic [31:0] inj_rs,
    output int          lat,
    output int          dcnt,
    output int          bbad,
    output logic [31:0] hf,
    output logic [31:0] rh,
    output logic [31:0] rl
  );
    lat  = -1;
    dcnt = 0;
    bbad = 0;
    hf   = '0;
    @(negedge clk);
    mif.start_i = 1'b1;
    mif.op_i    = op;
    mif.rs_i    = a;
    mif.rt_i    = b;
    mif.mthi_i  = mv;
    for (int i = 0; i <= 36; i++) begin
      @(negedge clk);
      if (i == 0) begin
        idle_inputs();
        hf = mif.hi_o;
      end
      if (i == inj) begin
        mif.start_i = 1'b1;
        mif.mtlo_i  = 1'b1;
        mif.rs_i    = inj_rs;
      end else if (i == inj + 1) begin
        idle_inputs();
      end
      if (mif.done_o) begin
        dcnt++;
        if (lat < 0) lat = i;
      end
      if (mif.busy_o !== (i <= 32)) bbad++;
    end
    rh = mif.hi_o;
    rl = mif.lo_o;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 4;
    if (mif.hi_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_hi got=%h exp=0", mif.hi_o);
    end
    if (mif.lo_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_lo got=%h exp=0", mif.lo_o);
    end
    if (mif.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got=%b exp=0", mif.busy_o);
    end
    if (mif.done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_done got=%b exp=0", mif.done_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_multu();
    int lat, dcnt, bbad;
    logic [31:0] hf, rh, rl;
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1, 32'h0,
          lat, dcnt, bbad, hf, rh, rl);
    checks += 5;
    if (rh !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL multu_hi got=%h exp=fffffffe", rh);
    end
    if (rl !== 32'h0000_0001) begin
      errors++;
      $display("FAIL multu_lo got=%h exp=00000001", rl);
    end
    if (lat != 33) begin
      errors++;
      $display("FAIL multu_latency got=%0d exp=33", lat);
    end
    if (dcnt != 1) begin
      errors++;
      $display("FAIL multu_done_pulses got=%0d exp=1", dcnt);
    end
    if (bbad != 0) begin
      errors++;
      $display("FAIL multu_busy_window bad_samples=%0d exp=0", bbad);
    end
  endtask

  task automatic test_mult();
    int lat, dcnt, bbad;
    logic [31:0] hf, rh, rl;
    do_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, -1, 32'h0,
          lat, dcnt, bbad, hf, rh, rl);
    checks += 2;
    if (rh !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL mult_neg_hi got=%h exp=ffffffff", rh);
    end
    if (rl !== 32'hFFFF_FFF1) begin
      errors++;
      $display("FAIL mult_neg_lo got=%h exp=fffffff1", rl);
    end
    do_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, -1, 32'h0,
          lat, dcnt, bbad, hf, rh, rl);
    checks += 2;
    if (rh !== 32'h4000_0000) begin
      errors++;
      $display("FAIL mult_min_hi got=%h exp=40000000", rh);
    end
    if (rl !== 32'h0) begin
      errors++;
      $display("FAIL mult_min_lo got=%h exp=0", rl);
    end
  endtask

  task automatic test_div();
    logic [1:0]  ops [5] = '{2'b10, 2'b11, 2'b11, 2'b10, 2'b11};
    logic [31:0] as  [5] = '{32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFFF,
                             32'h8000_0000, 32'h1234};
    logic [31:0] bs  [5] = '{32'd2, 32'd2, 32'hFFFF_FFFF,
                             32'hFFFF_FFFF, 32'h0};
    logic [31:0] ehi [5] = '{32'hFFFF_FFFF, 32'd1, 32'd0,
                             32'd0, 32'h1234};
    logic [31:0] elo [5] = '{32'hFFFF_FFFD, 32'd3, 32'd1,
                             32'h8000_0000, 32'hFFFF_FFFF};
    int lat, dcnt, bbad;
    logic [31:0] hf, rh, rl;
    for (int k = 0; k < 5; k++) begin
      do_op(ops[k], as[k], bs[k], 1'b0, -1, 32'h0,
            lat, dcnt, bbad, hf, rh, rl);
      checks += 3;
      if (rh !== ehi[k]) begin
        errors++;
        $display("FAIL div%0d_hi got=%h exp=%h", k, rh, ehi[k]);
      end
      if (rl !== elo[k]) begin
        errors++;
        $display("FAIL div%0d_lo got=%h exp=%h", k, rl, elo[k]);
      end
      if (lat != 33) begin
        errors++;
        $display("FAIL div%0d_latency got=%0d exp=33", k, lat);
      end
    end
  endtask

  task automatic test_moves();
    int lat, dcnt, bbad;
    logic [31:0] hf, rh, rl, lo_prev;
    lo_prev = mif.lo_o;
    @(negedge clk);
    mif.mthi_i = 1'b1;
    mif.rs_i   = 32'hA5A5_A5A5;
    @(negedge clk);
    idle_inputs();
    checks += 2;
    if (mif.hi_o !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL mthi_hi got=%h exp=a5a5a5a5", mif.hi_o);
    end
    if (mif.lo_o !== lo_prev) begin
      errors++;
      $display("FAIL mthi_lo_kept got=%h exp=%h", mif.lo_o, lo_prev);
    end
    mif.mthi_i = 1'b1;
    mif.mtlo_i = 1'b1;
    mif.rs_i   = 32'h5A5A_0001;
    @(negedge clk);
    idle_inputs();
    checks += 2;
    if (mif.hi_o !== 32'h5A5A_0001) begin
      errors++;
      $display("FAIL mthilo_hi got=%h exp=5a5a0001", mif.hi_o);
    end
    if (mif.lo_o !== 32'h5A5A_0001) begin
      errors++;
      $display("FAIL mthilo_lo got=%h exp=5a5a0001", mif.lo_o);
    end
    do_op(2'b01, 32'd3, 32'd4, 1'b0, 5, 32'h0000_DEAD,
          lat, dcnt, bbad, hf, rh, rl);
    checks += 5;
    if (hf !== 32'h5A5A_0001) begin
      errors++;
      $display("FAIL busy_hold_hi got=%h exp=5a5a0001", hf);
    end
    if (rh !== 32'h0) begin
      errors++;
      $display("FAIL busy_ignore_hi got=%h exp=0", rh);
    end
    if (rl !== 32'd12) begin
      errors++;
      $display("FAIL busy_ignore_lo got=%h exp=c", rl);
    end
    if (dcnt != 1) begin
      errors++;
      $display("FAIL busy_ignore_done got=%0d exp=1", dcnt);
    end
    if (bbad != 0) begin
      errors++;
      $display("FAIL busy_ignore_window bad=%0d exp=0", bbad);
    end
    do_op(2'b01, 32'd2, 32'd5, 1'b1, -1, 32'h0,
          lat, dcnt, bbad, hf, rh, rl);
    checks += 3;
    if (hf !== 32'h0) begin
      errors++;
      $display("FAIL start_mthi_drop got=%h exp=0", hf);
    end
    if (rh !== 32'h0) begin
      errors++;
      $display("FAIL start_mthi_hi got=%h exp=0", rh);
    end
    if (rl !== 32'd10) begin
      errors++;
      $display("FAIL start_mthi_lo got=%h exp=a", rl);
    end
  endtask

  task automatic test_reset_mid();
    int dcnt;
    int lat, bbad;
    logic [31:0] hf, rh, rl;
    dcnt = 0;
    @(negedge clk);
    mif.mthi_i = 1'b1;
    mif.mtlo_i = 1'b1;
    mif.rs_i   = 32'h0BAD_F00D;
    @(negedge clk);
    mif.start_i = 1'b1;
    mif.op_i    = 2'b11;
    mif.rs_i    = 32'd100;
    mif.rt_i    = 32'd7;
    mif.mthi_i  = 1'b0;
    mif.mtlo_i  = 1'b0;
    for (int i = 0; i <= 40; i++) begin
      @(negedge clk);
      if (i == 0) idle_inputs();
      if (i == 9) rst_n = 1'b0;
      if (i == 10) begin
        rst_n = 1'b1;
        checks += 3;
        if (mif.busy_o !== 1'b0) begin
          errors++;
          $display("FAIL midrst_busy got=%b exp=0", mif.busy_o);
        end
        if (mif.hi_o !== 32'h0) begin
          errors++;
          $display("FAIL midrst_hi got=%h exp=0", mif.hi_o);
        end
        if (mif.lo_o !== 32'h0) begin
          errors++;
          $display("FAIL midrst_lo got=%h exp=0", mif.lo_o);
        end
      end
      if (mif.done_o) dcnt++;
    end
    checks += 1;
    if (dcnt != 0) begin
      errors++;
      $display("FAIL midrst_no_done got=%0d exp=0", dcnt);
    end
    do_op(2'b01, 32'd2, 32'd3, 1'b0, -1, 32'h0,
          lat, dcnt, bbad, hf, rh, rl);
    checks += 3;
    if (rl !== 32'd6) begin
      errors++;
      $display("FAIL post_rst_lo got=%h exp=6", rl);
    end
    if (rh !== 32'h0) begin
      errors++;
      $display("FAIL post_rst_hi got=%h exp=0", rh);
    end
    if (lat != 33) begin
      errors++;
      $display("FAIL post_rst_latency got=%0d exp=33", lat);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_moves();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
